// File: rtl/uf_pkg.sv
// Shared union-find definitions: init sweep state encoding and the default
// node-index width / parent-array depth used by the find engine and memory.
package uf_pkg;

  typedef enum logic [0:0] {
    INIT_IDLE = 1'b0,
    INIT_RUN  = 1'b1
  } uf_init_state_t;

  localparam int UF_WIDTH = 32;
  localparam int UF_DEPTH = 1024;

endpackage

// File: rtl/uf_rd_pipe.sv
// Valid/data delay line of depth LAT. Each stage's data only loads with a valid
// beat, so the output data holds the last response between strobes.
module uf_rd_pipe #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LAT-1:0]   valid_q;
  logic [WIDTH-1:0] data_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) data_q[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_data  = data_q[LAT-1];

endmodule

// File: rtl/uf_parent_mem.sv
// Parent-array responder for the find engine with a core write port.
// Define UF_PARENT_AUTO_INIT_EN to build the parent[i] = i sweep and pending read.
module uf_parent_mem
  import uf_pkg::*;
#(
  parameter int WIDTH    = UF_WIDTH,
  parameter int DEPTH    = UF_DEPTH,
  parameter int READ_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_rd_en,
  input  logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_rdata,
  output logic             mem_ready,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             init_start,
  output logic             init_busy,
  output logic             rd_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

  logic [WIDTH-1:0] ram [DEPTH];

  logic             rd_issue;
  logic [WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             wr_fire;
  logic             sweep_we;
  logic [AW-1:0]    sweep_addr;

`ifdef UF_PARENT_AUTO_INIT_EN
  uf_init_state_t   state;
  logic [AW-1:0]    cnt;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_addr;
  logic             drop_q;
  logic             pend_issue;

  assign init_busy  = (state == INIT_RUN);
  assign wr_ready   = !init_busy && !rst;
  assign sweep_we   = init_busy && !rst;
  assign sweep_addr = cnt;
  assign rd_drop    = drop_q;

  // Reset parks the FSM in INIT_RUN so the sweep begins the cycle rst drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT_RUN;
      cnt   <= '0;
    end else if (init_start) begin
      state <= INIT_RUN;
      cnt   <= '0;
    end else if (state == INIT_RUN) begin
      cnt <= cnt + 1'b1;
      if (cnt == AW'(DEPTH - 1)) state <= INIT_IDLE;
    end
  end

  assign pend_issue = !init_busy && pend_valid;

  // A read colliding with the pending issue takes over the pending slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      drop_q     <= 1'b0;
    end else if (init_busy) begin
      if (mem_rd_en) begin
        if (pend_valid) begin
          drop_q <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_addr  <= mem_addr;
        end
      end
    end else if (pend_valid) begin
      pend_valid <= mem_rd_en;
      if (mem_rd_en) pend_addr <= mem_addr;
    end
  end

  assign rd_issue = pend_issue || (!init_busy && mem_rd_en);
  assign rd_addr  = pend_issue ? pend_addr : mem_addr;
`else
  logic unused_init_start;

  assign unused_init_start = init_start;
  assign init_busy  = 1'b0;
  assign wr_ready   = 1'b1;
  assign rd_drop    = 1'b0;
  assign sweep_we   = 1'b0;
  assign sweep_addr = '0;
  assign rd_issue   = mem_rd_en;
  assign rd_addr    = mem_addr;
`endif

  assign wr_fire = wr_en && wr_ready && (wr_addr < DEPTH_W);

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      ram[sweep_addr] <= WIDTH'(sweep_addr);
    end else if (wr_fire) begin
      ram[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // Out-of-range nodes read as their own root; same-address writes bypass the RAM.
  always_comb begin
    rd_data = '0;
    if (rd_addr >= DEPTH_W) begin
      rd_data = rd_addr;
    end else if (wr_fire && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = ram[rd_addr[AW-1:0]];
    end
  end

  uf_rd_pipe #(
    .WIDTH (WIDTH),
    .LAT   (READ_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_issue),
    .in_data   (rd_data),
    .out_valid (mem_ready),
    .out_data  (mem_rdata)
  );

endmodule

// File: tb/tb_uf_parent_mem.sv
// Scoreboarded bench for uf_parent_mem (DEPTH 16, READ_LAT 2); covers both
// builds of UF_PARENT_AUTO_INIT_EN.
module tb_uf_parent_mem;

  localparam int W   = 32;
  localparam int DEP = 16;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_rd_en;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_rdata;
  logic         mem_ready;
  logic         wr_en;
  logic [W-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         wr_ready;
  logic         init_start;
  logic         init_busy;
  logic         rd_drop;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

`ifdef UF_PARENT_AUTO_INIT_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  uf_parent_mem #(
    .WIDTH    (W),
    .DEPTH    (DEP),
    .READ_LAT (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .init_start (init_start),
    .init_busy  (init_busy),
    .rd_drop    (rd_drop)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // one input cycle; push=1 enqueues the expected response (exp_cyc -1 = timing not checked)
  task automatic step(input logic rd, input logic [W-1:0] ra, input logic push,
                      input logic [W-1:0] rexp, input logic timed,
                      input logic we, input logic [W-1:0] wa, input logic [W-1:0] wd);
    @(negedge clk);
    mem_rd_en = rd;
    mem_addr  = ra;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    if (rd && push) begin
      exp_q.push_back(rexp);
      exp_cyc_q.push_back(timed ? cyc + LAT : -1);
    end
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rd(input logic [W-1:0] a, input logic [W-1:0] e);
    step(1'b1, a, 1'b1, e, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [W-1:0] a, input logic [W-1:0] d);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, a, d);
  endtask

  task automatic wait_sweep();
    for (int i = 0; i < 100 && init_busy; i++) @(negedge clk);
    chk("sweep_done", {31'd0, init_busy}, 0);
  endtask

  // monitor: pops one expectation per mem_ready strobe, flags missing strobes
  always @(posedge clk) begin
    logic [W-1:0] d;
    int           c;
    #1;
    if (mem_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got strobe with data %0d, expected no strobe", mem_rdata);
      end else begin
        d = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        if (mem_rdata !== d) begin
          errors++;
          $display("FAIL rd_data: got %0d, expected %0d", mem_rdata, d);
        end
        if (c >= 0) begin
          checks++;
          if (cyc != c) begin
            errors++;
            $display("FAIL rd_latency: got strobe at cycle %0d, expected cycle %0d", cyc, c);
          end
        end
      end
    end else if (exp_q.size() > 0 && exp_cyc_q[0] >= 0 && cyc > exp_cyc_q[0]) begin
      checks++;
      errors++;
      $display("FAIL missing_resp: no strobe by cycle %0d, expected data %0d", cyc, exp_q[0]);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    mem_rd_en = 1'b0; mem_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    init_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_ready", {31'd0, mem_ready}, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_rd_drop", {31'd0, rd_drop}, 0);
    chk("rst_init_busy", {31'd0, init_busy}, {31'd0, AUTO});
    chk("rst_wr_ready", {31'd0, wr_ready}, {31'd0, !AUTO});
    rst = 1'b0;

`ifdef UF_PARENT_AUTO_INIT_EN
    // read 4 in the first cycle after reset waits for the sweep; a second read drops
    step(1'b1, 4, 1'b1, 4, 1'b0, 1'b0, '0, '0);
    step(1'b1, 5, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    idle();
    @(negedge clk);
    chk("rd_drop_set", {31'd0, rd_drop}, 1);
    chk("busy_in_sweep", {31'd0, init_busy}, 1);
    chk("wr_ready_in_sweep", {31'd0, wr_ready}, 0);
    wait_sweep();
    repeat (LAT + 3) @(negedge clk);
    chk("pending_drained", exp_q.size(), 0);
`endif

    wr(5, 9);
    idle();
    rd(5, 9);
    idle();
    wr(1, 1);
    wr(2, 2);
    wr(3, 3);
    rd(1, 1);
    rd(2, 2);
    rd(3, 3);
    // same-cycle read and write of node 7: write data wins
    step(1'b1, 7, 1'b1, 3, 1'b1, 1'b1, 7, 3);
    idle();
    rd(7, 3);
    rd(2000, 2000);
    rd(16, 16);
    wr(15, 4);
    rd(15, 4);
    // out-of-range write aliasing onto node 1 must be discarded
    wr(17, 99);
    rd(1, 1);
    step(1'b1, 5, 1'b1, 9, 1'b1, 1'b1, 6, 8);
    rd(6, 8);
    idle();
    repeat (LAT + 2) @(negedge clk);
    chk("rdata_held", mem_rdata, 8);

    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    chk("init_start_busy", {31'd0, init_busy}, {31'd0, AUTO});
    wait_sweep();
    chk("rd_drop_sticky", {31'd0, rd_drop}, {31'd0, AUTO});

    // reset with a read in flight: no strobe afterwards, outputs at reset values
    wr(5, 9);
    step(1'b1, 5, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    mem_rd_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_mem_ready", {31'd0, mem_ready}, 0);
    chk("rst2_mem_rdata", mem_rdata, 0);
    chk("rst2_rd_drop", {31'd0, rd_drop}, 0);
    rst = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    wait_sweep();
    rd(5, AUTO ? 5 : 9);
    idle();

    repeat (LAT + 4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
